// File: rtl/sidm_mac_pipelined.sv
// Pipelined SIDM multiply-accumulate: 18x12, dual 3x(6x6) or quad 3x(3x3) lanes,
// per-lane accumulation and a backpressured result stream.
module sidm_mac_pipelined #(
    parameter int PIPE_STAGES = 3,
    parameter int ACC_W       = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [35:0]      a,
    input  logic [35:0]      b,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [1:0]       mode,
    input  logic             acc_clear,
    input  logic             acc_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             mode_err
);

    localparam int LW2 = ACC_W / 2;
    localparam int LW4 = ACC_W / 4;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state;
    state_t             state_nx;
    logic               stall;
    logic               accept;
    logic               first;
    logic               mode_bad;
    logic [1:0]         mode_sel;
    logic [1:0]         mode_use;
    logic [1:0]         mode_q;
    logic [ACC_W-1:0]   part;
    logic [LW2-1:0]     sum2;
    logic [LW4-1:0]     sum4;

    logic [PIPE_STAGES-1:0] pv;
    logic [PIPE_STAGES-1:0] pf;
    logic [PIPE_STAGES-1:0] pl;
    logic [ACC_W-1:0]       pd [PIPE_STAGES];
    logic [1:0]             pm [PIPE_STAGES];

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nx;
    logic               done;

    function automatic logic signed [31:0] mul18(input logic [17:0] x,
                                                 input logic [11:0] y,
                                                 input logic xs,
                                                 input logic ys);
        logic signed [31:0] xe;
        logic signed [31:0] ye;
        xe = 32'(signed'({xs & x[17], x}));
        ye = 32'(signed'({ys & y[11], y}));
        return xe * ye;
    endfunction

    function automatic logic signed [13:0] mul6(input logic [5:0] x,
                                                input logic [5:0] y,
                                                input logic xs,
                                                input logic ys);
        logic signed [13:0] xe;
        logic signed [13:0] ye;
        xe = 14'(signed'({xs & x[5], x}));
        ye = 14'(signed'({ys & y[5], y}));
        return xe * ye;
    endfunction

    function automatic logic signed [7:0] mul3(input logic [2:0] x,
                                               input logic [2:0] y,
                                               input logic xs,
                                               input logic ys);
        logic signed [7:0] xe;
        logic signed [7:0] ye;
        xe = 8'(signed'({xs & x[2], x}));
        ye = 8'(signed'({ys & y[2], y}));
        return xe * ye;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    // FSM state register: tracks whether a group is open
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next state: every accepted beat opens or closes a group
    always_comb begin
        state_nx = state;
        if (accept) state_nx = acc_last ? IDLE : ACCUM;
    end

    // FSM outputs: group-start flag and effective (latched) mode
    always_comb begin
        first    = (state == IDLE) | acc_clear;
        mode_sel = first ? mode : mode_q;
        mode_bad = (mode_sel == 2'b11);
        mode_use = mode_bad ? 2'b00 : mode_sel;
    end

    // Mode latch and sticky illegal-mode flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= 2'b00;
            mode_err <= 1'b0;
        end else if (accept) begin
            if (first) mode_q <= mode_use;
            if (mode_bad) mode_err <= 1'b1;
        end
    end

    // Partial product per beat, packed into lanes
    always_comb begin
        part = '0;
        sum2 = '0;
        sum4 = '0;
        case (mode_use)
            2'b01: begin
                for (int j = 0; j < 2; j++) begin
                    sum2 = '0;
                    for (int k = 0; k < 3; k++) begin
                        sum2 = sum2 + LW2'(mul6(a[18*j+6*k +: 6],
                                                b[18*j+6*k +: 6],
                                                a_sign, b_sign));
                    end
                    part[j*LW2 +: LW2] = sum2;
                end
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    sum4 = '0;
                    for (int k = 0; k < 3; k++) begin
                        sum4 = sum4 + LW4'(mul3(a[(i/2)*18+(i%2)*3+6*k +: 3],
                                                b[(i/2)*18+(i%2)*3+6*k +: 3],
                                                a_sign, b_sign));
                    end
                    part[i*LW4 +: LW4] = sum4;
                end
            end
            default: begin
                part = ACC_W'(mul18(a[17:0], b[11:0], a_sign, b_sign));
            end
        endcase
    end

    // Product pipeline; frozen as a whole while the output is stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pd[i] <= '0;
                pm[i] <= 2'b00;
            end
        end else if (!stall) begin
            pv[0] <= accept;
            pf[0] <= first;
            pl[0] <= acc_last;
            pd[0] <= part;
            pm[0] <= mode_use;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
                pd[i] <= pd[i-1];
                pm[i] <= pm[i-1];
            end
        end
    end

    // Lane-isolated accumulate: no carry crosses a lane boundary
    always_comb begin
        acc_nx = acc;
        if (pf[PIPE_STAGES-1]) begin
            acc_nx = pd[PIPE_STAGES-1];
        end else begin
            case (pm[PIPE_STAGES-1])
                2'b01: begin
                    for (int j = 0; j < 2; j++)
                        acc_nx[j*LW2 +: LW2] = acc[j*LW2 +: LW2]
                                             + pd[PIPE_STAGES-1][j*LW2 +: LW2];
                end
                2'b10: begin
                    for (int i = 0; i < 4; i++)
                        acc_nx[i*LW4 +: LW4] = acc[i*LW4 +: LW4]
                                             + pd[PIPE_STAGES-1][i*LW4 +: LW4];
                end
                default: acc_nx = acc + pd[PIPE_STAGES-1];
            endcase
        end
    end

    // Accumulator and group-complete flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc  <= '0;
            done <= 1'b0;
        end else if (!stall) begin
            if (pv[PIPE_STAGES-1]) acc <= acc_nx;
            done <= pv[PIPE_STAGES-1] & pl[PIPE_STAGES-1];
        end
    end

    // Result register; holds value while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= done;
            if (done) out_data <= acc;
        end
    end

endmodule

// File: tb/tb_sidm_mac_pipelined.sv
// Directed bench for sidm_mac_pipelined: modes, accumulation, latency,
// backpressure, illegal mode and mid-group reset.
module tb_sidm_mac_pipelined;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] a;
    logic [35:0] b;
    logic        a_sign;
    logic        b_sign;
    logic [1:0]  mode;
    logic        acc_clear;
    logic        acc_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        mode_err;

    int checks = 0;
    int errors = 0;

    sidm_mac_pipelined #(.PIPE_STAGES(3), .ACC_W(48)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .mode      (mode),
        .acc_clear (acc_clear),
        .acc_last  (acc_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mode_err  (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [35:0] av, input logic [35:0] bv,
                        input logic as, input logic bs, input logic [1:0] m,
                        input logic clr, input logic lst);
        @(negedge clk);
        a = av; b = bv; a_sign = as; b_sign = bs; mode = m;
        acc_clear = clr; acc_last = lst; in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; acc_clear = 1'b0; acc_last = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [47:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 48'(out_valid), 48'd1);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00;
        acc_clear = 1'b0; acc_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_out_data", out_data, 48'd0);
        chk("rst_mode_err", 48'(mode_err), 48'd0);
        chk("rst_in_ready", 48'(in_ready), 48'd1);
        reset_n = 1'b1;

        // 1: 18x12 unsigned with exact latency
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        idle();
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_%0d", j), 48'(out_valid),
                48'(j == 4));
        end
        chk("t1_data", out_data, 48'h00003FFBF001);
        @(negedge clk);
        chk("t1_drop", 48'(out_valid), 48'd0);

        // 2: 18x12 signed, three-beat group
        beat(36'h20000, 36'h800, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        beat(36'h20000, 36'h800, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        beat(36'h20000, 36'h800, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        idle();
        expect_out("t2", 48'h000030000000);

        // 3: 6x6 signed, lanes isolated
        beat(36'h820820820, 36'h820820820, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        idle();
        expect_out("t3", 48'h000C00000C00);

        // 4: 3x3 signed then unsigned
        beat(36'h924924924, 36'h6DB6DB6DB, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        idle();
        expect_out("t4s", 48'hFDCFDCFDCFDC);
        beat(36'h924924924, 36'h6DB6DB6DB, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        idle();
        expect_out("t4u", 48'h024024024024);

        // mode latched on first beat; second beat's mode ignored
        beat(36'h820820820, 36'h820820820, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        beat(36'h820820820, 36'h820820820, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        idle();
        expect_out("latch", 48'h001800001800);

        // acc_clear mid-group discards old sum
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        beat(36'h00003, 36'h005, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        idle();
        expect_out("midclr", 48'h00000000000F);

        // 5: two groups back-to-back under 10 cycles of backpressure
        out_ready = 1'b0;
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        beat(36'h820820820, 36'h820820820, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        idle();
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_valid", 48'(out_valid), 48'd1);
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("bp_in_ready_%0d", j), 48'(in_ready), 48'd0);
            chk($sformatf("bp_data_%0d", j), out_data, 48'h00003FFBF001);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expect_out("bp_first", 48'h00003FFBF001);
        expect_out("bp_second", 48'h000C00000C00);
        chk("bp_no_extra", 48'(out_valid), 48'd0);

        // 6: illegal mode computed as 18x12 and flagged
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
        idle();
        expect_out("mode11", 48'h00003FFBF001);
        chk("mode_err_set", 48'(mode_err), 48'd1);

        // reset mid-group drops everything
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        beat(36'h3FFFF, 36'hFFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 48'(out_valid), 48'd0);
        chk("mrst_out_data", out_data, 48'd0);
        chk("mrst_mode_err", 48'(mode_err), 48'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mrst_no_emit", 48'(out_valid), 48'd0);
        beat(36'h924924924, 36'h6DB6DB6DB, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
        idle();
        expect_out("post_rst", 48'h024024024024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
